wb: RTL and testbench



---
 rtl/wb.sv | 148 ++++++++++++++
 tb/tb_wb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb.sv
// Write-back stage: register-file write port, HI/LO, CP0 STATUS/CAUSE/EPC and exception redirect.
// Optional macro WB_CP0_COUNT_EN adds a free-running CP0 COUNT register at {9,0}.
module wb #(
    parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         WB_valid,
    input  logic [118:0] MEM_WB_bus_r,
    output logic         rf_wen,
    output logic [4:0]   rf_wdest,
    output logic [31:0]  rf_wdata,
    output logic         WB_over,
    output logic [32:0]  exc_bus,
    output logic         cancel,
    output logic [4:0]   WB_wdest,
    output logic [31:0]  WB_pc,
    output logic [31:0]  HI_data,
    output logic [31:0]  LO_data
);

    localparam logic [7:0]  ADDR_STATUS = 8'h60;
    localparam logic [7:0]  ADDR_CAUSE  = 8'h68;
    localparam logic [7:0]  ADDR_EPC    = 8'h70;
    localparam logic [7:0]  ADDR_COUNT  = 8'h48;
    localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMSK = 32'h0000_FF03;

    logic        bus_rf_wen;
    logic [4:0]  bus_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        eret;
    logic [31:0] pc;

    assign {bus_rf_wen, bus_wdest, mem_result, lo_result,
            hi_write, lo_write, mfhi, mflo, mtc0, mfc0,
            cp0r_addr, syscall, brk, eret, pc} = MEM_WB_bus_r;

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_rdata;
    logic        exception;
    logic        mtc0_fire;

    assign exception = WB_valid & (syscall | brk);
    assign mtc0_fire = WB_valid & mtc0;

`ifdef WB_CP0_COUNT_EN
    logic [31:0] cp0_count;

    // A software write wins over the tick in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cp0_count <= 32'h0;
        else if (mtc0_fire && cp0r_addr == ADDR_COUNT)
            cp0_count <= mem_result;
        else
            cp0_count <= cp0_count + 32'd1;
    end
`endif

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0r_addr)
            ADDR_STATUS: cp0_rdata = cp0_status;
            ADDR_CAUSE:  cp0_rdata = cp0_cause;
            ADDR_EPC:    cp0_rdata = cp0_epc;
`ifdef WB_CP0_COUNT_EN
            ADDR_COUNT:  cp0_rdata = cp0_count;
`endif
            default:     cp0_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else if (WB_valid) begin
            if (hi_write) hi <= mem_result;
            if (lo_write) lo <= lo_result;
        end
    end

    // EPC keeps the first faulting pc when exceptions nest (EXL already set).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cp0_status <= STATUS_RST;
            cp0_cause  <= 32'h0;
            cp0_epc    <= 32'h0;
        end else if (WB_valid) begin
            if (mtc0 && cp0r_addr == ADDR_STATUS)
                cp0_status <= (cp0_status & ~STATUS_WMSK) | (mem_result & STATUS_WMSK);
            if (mtc0 && cp0r_addr == ADDR_CAUSE)
                cp0_cause[9:8] <= mem_result[9:8];
            if (mtc0 && cp0r_addr == ADDR_EPC)
                cp0_epc <= mem_result;
            if (syscall || brk) begin
                cp0_cause[6:2] <= syscall ? 5'd8 : 5'd9;
                cp0_status[1]  <= 1'b1;
                if (!cp0_status[1])
                    cp0_epc <= pc;
            end
            if (eret)
                cp0_status[1] <= 1'b0;
        end
    end

    always_comb begin
        rf_wdata = mem_result;
        if (mfhi)
            rf_wdata = hi;
        else if (mflo)
            rf_wdata = lo;
        else if (mfc0)
            rf_wdata = cp0_rdata;
    end

    logic        exc_valid;
    logic [31:0] exc_pc;

    assign exc_valid = exception | (WB_valid & eret);
    assign exc_pc    = exception ? EXC_ENTER_ADDR : (exc_valid ? cp0_epc : 32'h0);

    assign rf_wen   = WB_valid & bus_rf_wen & ~exception;
    assign rf_wdest = bus_wdest;
    assign WB_over  = WB_valid;
    assign exc_bus  = {exc_valid, exc_pc};
    assign cancel   = exc_valid;
    assign WB_wdest = bus_wdest & {5{WB_valid}};
    assign WB_pc    = pc;
    assign HI_data  = hi;
    assign LO_data  = lo;

endmodule

// File: tb/tb_wb.sv
// Self-checking bench for wb: directed scenarios plus a random stream checked
// against an architectural model of HI/LO and CP0 kept in plain variables.
module tb_wb;

    typedef struct packed {
        logic        valid;
        logic        rf_wen;
        logic [4:0]  wdest;
        logic [31:0] mem;
        logic [31:0] lo;
        logic        hw;
        logic        lw;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  addr;
        logic        sys;
        logic        brk;
        logic        eret;
        logic [31:0] pc;
    } instr_t;

    logic         clk;
    logic         resetn;
    logic         WB_valid;
    logic [118:0] MEM_WB_bus_r;
    logic         rf_wen;
    logic [4:0]   rf_wdest;
    logic [31:0]  rf_wdata;
    logic         WB_over;
    logic [32:0]  exc_bus;
    logic         cancel;
    logic [4:0]   WB_wdest;
    logic [31:0]  WB_pc;
    logic [31:0]  HI_data;
    logic [31:0]  LO_data;

    int cmpCount = 0;
    int errCount = 0;

    // Architectural model state
    logic [31:0] mHi, mLo, mStatus, mCause, mEpc, mCount;

    wb dut (
        .clk(clk), .resetn(resetn), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
        .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
        .exc_bus(exc_bus), .cancel(cancel), .WB_wdest(WB_wdest), .WB_pc(WB_pc),
        .HI_data(HI_data), .LO_data(LO_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [118:0] pack(input instr_t t);
        return {t.rf_wen, t.wdest, t.mem, t.lo, t.hw, t.lw, t.mfhi, t.mflo,
                t.mtc0, t.mfc0, t.addr, t.sys, t.brk, t.eret, t.pc};
    endfunction

    function automatic logic [31:0] modelCp0(input logic [7:0] a);
        if (a == 8'h60) return mStatus;
        if (a == 8'h68) return mCause;
        if (a == 8'h70) return mEpc;
`ifdef WB_CP0_COUNT_EN
        if (a == 8'h48) return mCount;
`endif
        return 32'h0;
    endfunction

    task automatic modelReset();
        mHi = 0; mLo = 0; mStatus = 32'h0040_0000; mCause = 0; mEpc = 0; mCount = 0;
    endtask

    // Drive one instruction, check the combinational outputs mid-cycle, then
    // advance the model across the next rising edge.
    task automatic applyStimulus(input instr_t t);
        logic [31:0] expData;
        logic [32:0] expExc;
        logic        fault;
        WB_valid     = t.valid;
        MEM_WB_bus_r = pack(t);
        @(negedge clk);
        fault   = t.valid & (t.sys | t.brk);
        expData = t.mfhi ? mHi : t.mflo ? mLo : t.mfc0 ? modelCp0(t.addr) : t.mem;
        expExc  = fault ? {1'b1, 32'h0} : (t.valid & t.eret) ? {1'b1, mEpc} : 33'h0;
        checkOutput("rf_wen",   {63'h0, rf_wen},   {63'h0, t.valid & t.rf_wen & ~fault});
        checkOutput("rf_wdest", {59'h0, rf_wdest}, {59'h0, t.wdest});
        checkOutput("rf_wdata", {32'h0, rf_wdata}, {32'h0, expData});
        checkOutput("WB_over",  {63'h0, WB_over},  {63'h0, t.valid});
        checkOutput("exc_bus",  {31'h0, exc_bus},  {31'h0, expExc});
        checkOutput("cancel",   {63'h0, cancel},   {63'h0, expExc[32]});
        checkOutput("WB_wdest", {59'h0, WB_wdest}, {59'h0, t.valid ? t.wdest : 5'd0});
        checkOutput("WB_pc",    {32'h0, WB_pc},    {32'h0, t.pc});
        checkOutput("HI_data",  {32'h0, HI_data},  {32'h0, mHi});
        checkOutput("LO_data",  {32'h0, LO_data},  {32'h0, mLo});
        mCount = mCount + 1;
        if (t.valid) begin
            if (t.hw) mHi = t.mem;
            if (t.lw) mLo = t.lo;
            if (t.mtc0) begin
                case (t.addr)
                    8'h60: mStatus = {mStatus[31:16], t.mem[15:8], mStatus[7:2], t.mem[1:0]};
                    8'h68: mCause  = {mCause[31:10], t.mem[9:8], mCause[7:0]};
                    8'h70: mEpc    = t.mem;
`ifdef WB_CP0_COUNT_EN
                    8'h48: mCount  = t.mem;
`endif
                    default: ;
                endcase
            end
            if (t.sys || t.brk) begin
                if (mStatus[1] == 1'b0) mEpc = t.pc;
                mCause[6:2] = t.sys ? 5'd8 : 5'd9;
                mStatus[1]  = 1'b1;
            end
            if (t.eret) mStatus[1] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t randInstr();
        instr_t t;
        logic [7:0] addrs [5];
        addrs = '{8'h60, 8'h68, 8'h70, 8'h48, 8'h00};
        t        = '0;
        t.valid  = ($urandom_range(0, 7) != 0);
        t.rf_wen = $urandom_range(0, 1);
        t.wdest  = 5'($urandom);
        t.mem    = $urandom;
        t.lo     = $urandom;
        t.pc     = {$urandom, 2'b00} >> 2 << 2;
        t.addr   = addrs[$urandom_range(0, 4)];
        if (t.addr == 8'h00) t.addr = 8'($urandom);
        case ($urandom_range(0, 9))
            0: begin t.hw = 1; t.lw = 1; end
            1: t.hw = 1;
            2: t.mfhi = 1;
            3: t.mflo = 1;
            4: t.mtc0 = 1;
            5: t.mfc0 = 1;
            6: t.sys = 1;
            7: t.brk = 1;
            8: t.eret = 1;
            default: t.lw = $urandom_range(0, 1);
        endcase
        return t;
    endfunction

    function automatic instr_t mk(input logic [31:0] pc);
        instr_t t;
        t = '0;
        t.valid = 1'b1;
        t.pc = pc;
        return t;
    endfunction

    instr_t t;

    initial begin
        // Reset state: CP0 STATUS visible through the mfc0 path while held in reset
        resetn   = 1'b0;
        WB_valid = 1'b0;
        t = '0; t.mfc0 = 1; t.addr = 8'h60;
        MEM_WB_bus_r = pack(t);
        #12;
        checkOutput("rst_rf_wen",  {63'h0, rf_wen},  64'h0);
        checkOutput("rst_exc_bus", {31'h0, exc_bus}, 64'h0);
        checkOutput("rst_cancel",  {63'h0, cancel},  64'h0);
        checkOutput("rst_status",  {32'h0, rf_wdata}, 64'h0040_0000);
        checkOutput("rst_hi",      {32'h0, HI_data}, 64'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        modelReset();

        // Directed scenarios
        t = mk(32'h100); t.rf_wen = 1; t.wdest = 5; t.mem = 32'h1234_5678; applyStimulus(t);
        t = mk(32'h104); t.hw = 1; t.lw = 1; t.mem = 32'hAAAA_0001; t.lo = 32'h5555_0002; applyStimulus(t);
        t = mk(32'h108); t.rf_wen = 1; t.wdest = 2; t.mfhi = 1; applyStimulus(t);
        t = mk(32'h10C); t.rf_wen = 1; t.wdest = 3; t.mflo = 1; applyStimulus(t);
        t = mk(32'hBFC0_0100); t.rf_wen = 1; t.wdest = 4; t.sys = 1; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h70; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h68; applyStimulus(t);
        t = mk(32'h200); t.brk = 1; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h70; applyStimulus(t);
        t = mk(32'h204); t.eret = 1; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h60; applyStimulus(t);
        t = mk(32'h0); t.mtc0 = 1; t.addr = 8'h60; t.mem = 32'hFFFF_FFFF; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h60; applyStimulus(t);
        t = mk(32'h0); t.mtc0 = 1; t.addr = 8'h70; t.mem = 32'h0000_0400; applyStimulus(t);
        t = mk(32'h0); t.eret = 1; applyStimulus(t);
        t = mk(32'h0); t.mtc0 = 1; t.addr = 8'h48; t.mem = 32'hFFFF_FFFE; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h48; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h48; applyStimulus(t);
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h48; applyStimulus(t);
        t = '0; t.hw = 1; t.sys = 1; t.mem = 32'hDEAD_BEEF; applyStimulus(t);

        // Random stream
        for (int i = 0; i < 400; i++) begin
            t = randInstr();
            applyStimulus(t);
        end

        // Reset asserted mid-instruction clears everything
        t = mk(32'h300); t.hw = 1; t.lw = 1; t.mem = 32'h1111_2222; t.lo = 32'h3333_4444;
        WB_valid = 1'b1;
        MEM_WB_bus_r = pack(t);
        @(negedge clk);
        resetn = 1'b0;
        WB_valid = 1'b0;
        #1;
        checkOutput("midrst_hi", {32'h0, HI_data}, 64'h0);
        checkOutput("midrst_lo", {32'h0, LO_data}, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("midrst_hold_hi", {32'h0, HI_data}, 64'h0);
        resetn = 1'b1;
        modelReset();
        t = mk(32'h0); t.mfc0 = 1; t.addr = 8'h60; applyStimulus(t);
        for (int i = 0; i < 100; i++) begin
            t = randInstr();
            applyStimulus(t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
